// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding control for the IF/ID, ID/EX and EX/MEM stage registers.
//   Inputs : clk, aclr (async, active-low), D/E source regs, E/M/W destinations and write enables,
//            wb_selE, br_takenE, mem_busy.
//   Outputs: stallF/D/E/M, flushD/E (sclr), fwd_aE/fwd_bE (00 regfile, 01 M, 10 W),
//            mem_timeout (sticky), stall_cnt/flush_cnt.
//   Define HAZ_PERF_CNT_EN to build the saturating performance counters; otherwise they read 0.
module hazard_ctrl #(
    parameter logic [1:0] WB_LOAD     = 2'b01,
    parameter int         MEM_TIMEOUT = 255,
    parameter int         CNT_W       = 32
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic [4:0]       rs1_addrD,
    input  logic [4:0]       rs2_addrD,
    input  logic [4:0]       rs1_addrE,
    input  logic [4:0]       rs2_addrE,
    input  logic [4:0]       rd_addrE,
    input  logic             rd_wrenE,
    input  logic [1:0]       wb_selE,
    input  logic [4:0]       rd_addrM,
    input  logic             rd_wrenM,
    input  logic [4:0]       rd_addrW,
    input  logic             rd_wrenW,
    input  logic             br_takenE,
    input  logic             mem_busy,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic [1:0]       fwd_aE,
    output logic [1:0]       fwd_bE,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef enum logic [1:0] {BOOT, RUN, WAIT} state_t;
    localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);
    state_t      state;
    logic        pendBr;
    logic [15:0] waitCnt;
    logic        boot, lu, br, busyAct, brAct, luAct;
    assign boot = state == BOOT;
    assign lu = rd_wrenE && wb_selE == WB_LOAD && rd_addrE != 5'd0 &&
                (rd_addrE == rs1_addrD || rd_addrE == rs2_addrD);
    assign br = br_takenE | pendBr;
    // Priority: memory wait freezes everything, then redirect, then load-use bubble.
    assign busyAct = !boot && mem_busy;
    assign brAct   = !boot && !mem_busy && br;
    assign luAct   = !boot && !mem_busy && !br && lu;
    assign stallF = busyAct | luAct;
    assign stallD = busyAct | luAct;
    assign stallE = busyAct;
    assign stallM = busyAct;
    assign flushD = boot | brAct;
    assign flushE = boot | brAct | luAct;
    function automatic logic [1:0] fwdSel(input logic [4:0] rs);
        return (rd_wrenM && rd_addrM != 5'd0 && rd_addrM == rs) ? 2'b01 :
               (rd_wrenW && rd_addrW != 5'd0 && rd_addrW == rs) ? 2'b10 : 2'b00;
    endfunction
    assign fwd_aE = boot ? 2'b00 : fwdSel(rs1_addrE);
    assign fwd_bE = boot ? 2'b00 : fwdSel(rs2_addrE);
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state       <= BOOT;
            pendBr      <= 1'b0;
            waitCnt     <= 16'd0;
            mem_timeout <= 1'b0;
        end else if (boot) begin
            state <= RUN;
        end else begin
            state <= mem_busy ? WAIT : RUN;
            // A redirect seen during a wait is held; any non-busy cycle consumes it.
            pendBr  <= mem_busy ? (pendBr | br_takenE) : 1'b0;
            waitCnt <= !mem_busy ? 16'd0 : (waitCnt >= TIMEOUT ? waitCnt : waitCnt + 16'd1);
            if (mem_busy && waitCnt >= TIMEOUT - 16'd1)
                mem_timeout <= 1'b1;
        end
    end
`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stallCnt, flushCnt;
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (stallF && !(&stallCnt))
                stallCnt <= stallCnt + 1'b1;
            if (brAct && !(&flushCnt))
                flushCnt <= flushCnt + 1'b1;
        end
    end
    assign stall_cnt = stallCnt;
    assign flush_cnt = flushCnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl (MEM_TIMEOUT=4).
module tb_hazard_ctrl;
    logic        clk = 1'b0;
    logic        aclr;
    logic [4:0]  rs1_addrD, rs2_addrD, rs1_addrE, rs2_addrE, rd_addrE, rd_addrM, rd_addrW;
    logic        rd_wrenE, rd_wrenM, rd_wrenW, br_takenE, mem_busy;
    logic [1:0]  wb_selE;
    logic        stallF, stallD, stallE, stallM, flushD, flushE, mem_timeout;
    logic [1:0]  fwd_aE, fwd_bE;
    logic [31:0] stall_cnt, flush_cnt;
    logic [5:0]  ctl;
    int          vectors = 0;
    int          errs = 0;
    int          expStall = 0;
    int          expFlush = 0;
`ifdef HAZ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    always #5 clk = ~clk;
    assign ctl = {stallF, stallD, stallE, stallM, flushD, flushE};

    hazard_ctrl #(.WB_LOAD(2'b01), .MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .aclr(aclr),
        .rs1_addrD(rs1_addrD), .rs2_addrD(rs2_addrD),
        .rs1_addrE(rs1_addrE), .rs2_addrE(rs2_addrE),
        .rd_addrE(rd_addrE), .rd_wrenE(rd_wrenE), .wb_selE(wb_selE),
        .rd_addrM(rd_addrM), .rd_wrenM(rd_wrenM),
        .rd_addrW(rd_addrW), .rd_wrenW(rd_wrenW),
        .br_takenE(br_takenE), .mem_busy(mem_busy),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE),
        .fwd_aE(fwd_aE), .fwd_bE(fwd_bE),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        {rs1_addrD, rs2_addrD, rs1_addrE, rs2_addrE, rd_addrE, rd_addrM, rd_addrW} = '0;
        {rd_wrenE, rd_wrenM, rd_wrenW, br_takenE, mem_busy} = '0;
        wb_selE = 2'b00;
    endtask

    // Check control outputs for the current RUN/WAIT cycle, update the counter model, advance.
    task automatic cyc(input string tag, input logic [5:0] expCtl);
        #1;
        chk(tag, 32'(ctl), 32'(expCtl));
        if (expCtl[5]) expStall++;
        if (expCtl[1]) expFlush++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        aclr = 1'b0;
        clr();
        mem_busy = 1'b1;
        rd_wrenM = 1'b1; rd_addrM = 5'd7; rs1_addrE = 5'd7;
        #3;
        chk("rst_ctl", 32'(ctl), 32'(6'b000011));
        chk("rst_fwd", 32'(fwd_aE), 32'(2'b00));
        chk("rst_timeout", 32'(mem_timeout), 32'd0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        chk("rst_flush_cnt", flush_cnt, 32'd0);
        #9;
        aclr = 1'b1;
        #1;
        chk("boot_ctl_busy_ignored", 32'(ctl), 32'(6'b000011));
        chk("boot_fwd_forced", 32'(fwd_aE), 32'(2'b00));
        @(posedge clk);
        #1;
        mem_busy = 1'b0;
        #1;
        chk("run_fwd_m", 32'(fwd_aE), 32'(2'b01));
        cyc("run_idle", 6'b000000);
        chk("boot_no_wait_cnt", 32'(mem_timeout), 32'd0);

        clr(); rd_addrE = 5'd5; rd_wrenE = 1'b1; wb_selE = 2'b01; rs2_addrD = 5'd5;
        cyc("lu_rs2", 6'b110001);
        rd_addrE = 5'd0;
        cyc("lu_x0", 6'b000000);
        clr(); rd_addrE = 5'd9; rd_wrenE = 1'b1; wb_selE = 2'b01; rs1_addrD = 5'd9;
        cyc("lu_rs1", 6'b110001);
        wb_selE = 2'b00;
        cyc("lu_not_load", 6'b000000);
        wb_selE = 2'b01; rd_wrenE = 1'b0;
        cyc("lu_no_wren", 6'b000000);
        rd_wrenE = 1'b1; br_takenE = 1'b1;
        cyc("br_over_lu", 6'b000011);
        clr();
        cyc("after_br", 6'b000000);

        mem_busy = 1'b1;
        cyc("busy1", 6'b111100);
        br_takenE = 1'b1;
        cyc("busy2_br", 6'b111100);
        br_takenE = 1'b0;
        cyc("busy3", 6'b111100);
        mem_busy = 1'b0;
        cyc("pend_br_release", 6'b000011);
        cyc("pend_br_cleared", 6'b000000);
        chk("short_wait_no_timeout", 32'(mem_timeout), 32'd0);

        clr(); rd_wrenM = 1'b1; rd_wrenW = 1'b1; rd_addrM = 5'd7; rd_addrW = 5'd7;
        rs1_addrE = 5'd7; rs2_addrE = 5'd3;
        #1;
        chk("fwd_a_m_prio", 32'(fwd_aE), 32'(2'b01));
        chk("fwd_b_none", 32'(fwd_bE), 32'(2'b00));
        rd_wrenM = 1'b0; rs2_addrE = 5'd7;
        #1;
        chk("fwd_a_w", 32'(fwd_aE), 32'(2'b10));
        chk("fwd_b_w", 32'(fwd_bE), 32'(2'b10));
        rd_wrenM = 1'b1; rd_addrM = 5'd0; rd_addrW = 5'd0; rs1_addrE = 5'd0; rs2_addrE = 5'd0;
        #1;
        chk("fwd_a_x0", 32'(fwd_aE), 32'(2'b00));
        chk("fwd_b_x0", 32'(fwd_bE), 32'(2'b00));
        rd_addrM = 5'd4; rd_addrW = 5'd6; rs1_addrE = 5'd6; rs2_addrE = 5'd4;
        #1;
        chk("fwd_a_w_diff", 32'(fwd_aE), 32'(2'b10));
        chk("fwd_b_m_diff", 32'(fwd_bE), 32'(2'b01));

        clr();
        @(posedge clk);
        #1;
        for (int k = 1; k <= 6; k++) begin
            mem_busy = 1'b1;
            chk($sformatf("timeout_flag_%0d", k), 32'(mem_timeout), 32'(k > 4));
            cyc($sformatf("timeout_stall_%0d", k), 6'b111100);
        end
        mem_busy = 1'b0;
        chk("timeout_sticky_1", 32'(mem_timeout), 32'd1);
        cyc("timeout_release", 6'b000000);
        chk("timeout_sticky_2", 32'(mem_timeout), 32'd1);
        chk("stall_cnt", stall_cnt, PERF ? 32'(expStall) : 32'd0);
        chk("flush_cnt", flush_cnt, PERF ? 32'(expFlush) : 32'd0);

        #2;
        aclr = 1'b0;
        #1;
        chk("rst2_timeout", 32'(mem_timeout), 32'd0);
        chk("rst2_ctl", 32'(ctl), 32'(6'b000011));
        chk("rst2_stall_cnt", stall_cnt, 32'd0);
        chk("rst2_flush_cnt", flush_cnt, 32'd0);
        @(posedge clk);
        #1;
        aclr = 1'b1;
        @(posedge clk);
        #1;
        cyc("rst2_run", 6'b000000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
